// File: rtl/pulse_stretcher.sv
// Stretches single-cycle pulse events into a programmable-width level, then enforces a hold-off gap.
// Optional build macro PULSE_STRETCHER_RETRIGGER_EN: events sampled in ACTIVE reload the width counter.
module pulse_stretcher #(
    parameter int CNT_W   = 8,
    parameter int HOLDOFF = 2,
    parameter int DROP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    input  logic [CNT_W-1:0]  width,
    output logic              out,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt,
    input  logic              drop_clr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [7:0]        HOLD_LOAD = (HOLDOFF > 0) ? 8'(HOLDOFF - 1) : 8'd0;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [DROP_W-1:0] DROP_ONE  = DROP_W'(1);
    localparam logic [DROP_W-1:0] DROP_MAX  = {DROP_W{1'b1}};

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  act_cnt_r;
    logic [CNT_W-1:0]  act_cnt_s;
    logic [7:0]        hold_cnt_r;
    logic [7:0]        hold_cnt_s;
    logic [DROP_W-1:0] drop_cnt_r;
    logic              drop_s;
    logic              out_r;
    logic              busy_r;

    // A zero width request still yields a one-cycle strobe.
    function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] w);
        logic [CNT_W-1:0] v;
        if (w == {CNT_W{1'b0}}) begin
            v = {CNT_W{1'b0}};
        end else begin
            v = w - CNT_ONE;
        end
        return v;
    endfunction

    // Next-state, counter reloads and drop detection.
    always_comb begin
        state_s    = state_r;
        act_cnt_s  = act_cnt_r;
        hold_cnt_s = hold_cnt_r;
        drop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pulse_in) begin
                    state_s   = ST_ACTIVE;
                    act_cnt_s = load_val(width);
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
                if (pulse_in) begin
                    act_cnt_s = load_val(width);
                end else if (act_cnt_r != {CNT_W{1'b0}}) begin
`else
                drop_s = pulse_in;
                if (act_cnt_r != {CNT_W{1'b0}}) begin
`endif
                    act_cnt_s = act_cnt_r - CNT_ONE;
                end else if (HOLDOFF == 0) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s    = ST_HOLD;
                    hold_cnt_s = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                drop_s = pulse_in;
                if (hold_cnt_r != 8'd0) begin
                    hold_cnt_s = hold_cnt_r - 8'd1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                act_cnt_s  = {CNT_W{1'b0}};
                hold_cnt_s = 8'd0;
            end
        endcase
    end

    // State, counters and registered output decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            act_cnt_r  <= {CNT_W{1'b0}};
            hold_cnt_r <= 8'd0;
            out_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            act_cnt_r  <= act_cnt_s;
            hold_cnt_r <= hold_cnt_s;
            out_r      <= (state_s == ST_ACTIVE);
            busy_r     <= (state_s != ST_IDLE);
        end
    end

    // Saturating drop counter; clear takes priority over a same-cycle drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_r <= {DROP_W{1'b0}};
        end else if (drop_clr) begin
            drop_cnt_r <= {DROP_W{1'b0}};
        end else if (drop_s && (drop_cnt_r != DROP_MAX)) begin
            drop_cnt_r <= drop_cnt_r + DROP_ONE;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign out      = out_r;
    assign busy     = busy_r;
    assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed self-checking bench for pulse_stretcher (CNT_W=8, HOLDOFF=2, DROP_W=8).
// Inputs change and outputs are observed on the falling clock edge.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst;
    logic       pulse_in;
    logic [7:0] width;
    logic       out;
    logic       busy;
    logic [7:0] drop_cnt;
    logic       drop_clr;

    int checks = 0;
    int errors = 0;

    pulse_stretcher #(.CNT_W(8), .HOLDOFF(2), .DROP_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .width    (width),
        .out      (out),
        .busy     (busy),
        .drop_cnt (drop_cnt),
        .drop_clr (drop_clr)
    );

    always #5 clk = ~clk;

    // Counts out-high and busy cycles from the current falling edge until busy drops.
    task automatic measure(output int n_out, output int n_busy, output bit timed_out);
        n_out     = 0;
        n_busy    = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 700; i++) begin
            if (busy !== 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            if (out === 1'b1) n_out++;
            n_busy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; pulse_in = 1'b0; drop_clr = 1'b0; width = 8'd5;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (out !== 1'b0)       begin errors++; $display("FAIL reset_out: got %b expected 0", out); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (drop_cnt !== 8'd0)  begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
    endtask

    task automatic test_basic;
        int no, nb; bit to;
        width = 8'd5; pulse_in = 1'b1;
        @(negedge clk);
        pulse_in = 1'b0; width = 8'd9;
        checks++; if (out !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b expected 1", out); end
        measure(no, nb, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b expected 0", to); end
        checks++; if (no !== 5)    begin errors++; $display("FAIL basic_out_len: got %0d expected 5", no); end
        checks++; if (nb !== 7)    begin errors++; $display("FAIL basic_busy_len: got %0d expected 7", nb); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL basic_drop: got %0d expected 0", drop_cnt); end
    endtask

    task automatic test_zero_width;
        int no, nb; bit to;
        width = 8'd0; pulse_in = 1'b1;
        @(negedge clk);
        pulse_in = 1'b0;
        measure(no, nb, to);
        checks++; if (no !== 1 || to !== 1'b0) begin errors++; $display("FAIL zero_out_len: got %0d (timeout %b) expected 1", no, to); end
        checks++; if (nb !== 3) begin errors++; $display("FAIL zero_busy_len: got %0d expected 3", nb); end
        width = 8'd255; pulse_in = 1'b1;
        @(negedge clk);
        pulse_in = 1'b0;
        measure(no, nb, to);
        checks++; if (no !== 255 || to !== 1'b0) begin errors++; $display("FAIL max_out_len: got %0d (timeout %b) expected 255", no, to); end
        checks++; if (nb !== 257) begin errors++; $display("FAIL max_busy_len: got %0d expected 257", nb); end
    endtask

    task automatic test_active_event;
        int no, nb, exp_out, exp_busy, exp_drop; bit to;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        exp_out = 7; exp_busy = 9; exp_drop = 0;
`else
        exp_out = 5; exp_busy = 7; exp_drop = 1;
`endif
        drop_clr = 1'b1;
        @(negedge clk);
        drop_clr = 1'b0; width = 8'd5; pulse_in = 1'b1;
        @(negedge clk);
        pulse_in = 1'b0;
        @(negedge clk);
        pulse_in = 1'b1;
        @(negedge clk);
        pulse_in = 1'b0;
        measure(no, nb, to);
        checks++; if (no + 2 !== exp_out || to !== 1'b0) begin errors++; $display("FAIL active_out_len: got %0d expected %0d", no + 2, exp_out); end
        checks++; if (nb + 2 !== exp_busy) begin errors++; $display("FAIL active_busy_len: got %0d expected %0d", nb + 2, exp_busy); end
        checks++; if (drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL active_drop: got %0d expected %0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_holdoff_event;
        int no, nb; bit to;
        drop_clr = 1'b1;
        @(negedge clk);
        drop_clr = 1'b0; width = 8'd3; pulse_in = 1'b1;
        @(negedge clk);
        pulse_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL hold_state: got out=%b busy=%b expected out=0 busy=1", out, busy); end
        pulse_in = 1'b1;
        @(negedge clk);
        pulse_in = 1'b0;
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL hold_drop: got %0d expected 1", drop_cnt); end
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL hold_ignored: got out=%b expected 0", out); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_idle: got busy=%b expected 0", busy); end
        pulse_in = 1'b1;
        @(negedge clk);
        pulse_in = 1'b0;
        checks++; if (out !== 1'b1) begin errors++; $display("FAIL hold_accept: got out=%b expected 1", out); end
        measure(no, nb, to);
        checks++; if (no !== 3 || nb !== 5 || to !== 1'b0) begin errors++; $display("FAIL hold_second_len: got out=%0d busy=%0d expected out=3 busy=5", no, nb); end
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL hold_drop_final: got %0d expected 1", drop_cnt); end
    endtask

    task automatic test_saturation;
        width = 8'd0;
        for (int r = 0; r < 160; r++) begin
            pulse_in = 1'b1;
            @(negedge clk);
            pulse_in = 1'b0;
            @(negedge clk);
            pulse_in = 1'b1;
            repeat (2) @(negedge clk);
            pulse_in = 1'b0;
        end
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_value: got %0d expected 255", drop_cnt); end
        pulse_in = 1'b1;
        @(negedge clk);
        pulse_in = 1'b0;
        @(negedge clk);
        pulse_in = 1'b1; drop_clr = 1'b1;
        @(negedge clk);
        drop_clr = 1'b0;
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL clr_wins: got %0d expected 0", drop_cnt); end
        @(negedge clk);
        pulse_in = 1'b0;
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL clr_then_drop: got %0d expected 1", drop_cnt); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int no, nb; bit to;
        width = 8'd10; pulse_in = 1'b1;
        @(negedge clk);
        pulse_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_abort: got out=%b busy=%b expected 0 0", out, busy); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_mid_drop: got %0d expected 0", drop_cnt); end
        @(negedge clk);
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL rst_mid_residual: got out=%b expected 0", out); end
        pulse_in = 1'b1;
        @(negedge clk);
        pulse_in = 1'b0;
        measure(no, nb, to);
        checks++; if (no !== 10 || to !== 1'b0) begin errors++; $display("FAIL rst_mid_after_len: got %0d expected 10", no); end
        checks++; if (nb !== 12) begin errors++; $display("FAIL rst_mid_after_busy: got %0d expected 12", nb); end
    endtask

    initial begin
        rst = 1'b1; pulse_in = 1'b0; drop_clr = 1'b0; width = 8'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero_width();
        test_active_event();
        test_holdoff_event();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Receive-side counterpart to the team's level-to-pulse one-shot. It converts a single-cycle pulse event into an output level held for a programmable number of clock cycles.
- After each stretched pulse it enforces a hold-off gap, and it counts every pulse event it drops.
- Sits downstream of pulse generators (button/event one-shots) and drives LEDs, enables and slower consumers that need a wide strobe.

Parameters:
- CNT_W, 8, width of the width port and of the internal active counter
- HOLDOFF, 2, idle gap in cycles after each stretched pulse; legal range 0..255
- DROP_W, 8, width of the saturating dropped-pulse counter

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- pulse_in  input  1  pulse event; every cycle sampled high is one event
- width  input  CNT_W  requested output width in cycles; sampled only on an accepted event
- out  output  1  stretched pulse, registered
- busy  output  1  high whenever state is not IDLE
- drop_cnt  output  DROP_W  saturating count of rejected events
- drop_clr  input  1  synchronous clear of drop_cnt

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, active counter=0, hold-off counter=0, drop_cnt=0; out=0, busy=0 from the following cycle.
- Reset mid-operation aborts immediately; no residual pulse.
- States and outputs:
  - IDLE: out=0, busy=0
  - ACTIVE: out=1, busy=1
  - HOLDOFF: out=0, busy=1
- out and busy are decoded from the registered state only; no combinational path from pulse_in.
- IDLE:
  - pulse_in=1 -> ACTIVE; active counter <= W-1, where W = width, or 1 if width==0.
  - Latency: out rises the cycle after the one in which pulse_in is sampled high.
- ACTIVE:
  - counter!=0 -> decrement.
  - counter==0 -> HOLDOFF with hold-off counter <= HOLDOFF-1, or -> IDLE directly if HOLDOFF==0.
  - out is therefore high for exactly W consecutive cycles.
- HOLDOFF:
  - counter!=0 -> decrement.
  - counter==0 -> IDLE.
  - Occupies exactly HOLDOFF cycles.
- Event acceptance:
  - Only in IDLE, except as extended by the optional feature.
  - Events in ACTIVE or HOLDOFF are dropped: no effect on state, counters or out.
  - With HOLDOFF==0, an event in the last ACTIVE cycle is dropped.
- drop_cnt:
  - +1 per dropped event; saturates at all-ones.
  - drop_clr=1 -> 0 next cycle; clear wins over a simultaneous increment.
- width changes while not accepting an event have no effect on a pulse in progress.
- pulse_in held high for N cycles = N events: the first may be accepted, the rest count as drops while not IDLE.

Optional Feature:
- Macro: PULSE_STRETCHER_RETRIGGER_EN
- Defined: an event sampled in ACTIVE reloads the active counter with W-1 from the current width.
  - out stays high continuously, ending W cycles after the retrigger cycle.
  - Not counted as a drop.
- Events in HOLDOFF remain drops.
- Undefined: events in ACTIVE are drops, as in Behaviour.

Test Plan:
- Basic stretch: HOLDOFF=2, width=5, single pulse_in in cycle 10 -> out=1 in cycles 11-15, busy=1 in cycles 11-17, IDLE in cycle 18, drop_cnt=0.
- Zero width: width=0 -> out high for exactly 1 cycle. width=255 -> out high for exactly 255 cycles.
- Event in ACTIVE: width=5, second pulse 2 cycles after out rises.
  - Without RETRIGGER_EN -> out still 5 cycles, drop_cnt=1.
  - With it -> out high 7 cycles continuously, drop_cnt=0.
- Event in HOLDOFF: pulse during hold-off (both builds) -> ignored, drop_cnt+1. A pulse in the first IDLE cycle is accepted normally.
- Saturation and clear: DROP_W=8, 300 drops -> drop_cnt=255. drop_clr asserted in the same cycle as a drop -> drop_cnt=0.
- Reset mid-ACTIVE: width=10, rst in the 3rd out cycle -> out=0 and busy=0 next cycle, drop_cnt=0. A following pulse gives a full 10-cycle out.
